// File: rtl/multi_sync_filter.sv
// Multi-channel async-level synchronizer: per-channel flop chain into dst_clk,
// stability filter, edge pulses and a sticky glitch flag.

module multi_sync_filter_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   F           = 4,
    parameter int   CW          = 3,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic dst_clk,
    input  logic rst_n,
    input  logic async_in,
    input  logic glitch_clr,
    output logic sync_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic glitch_seen
);
    localparam logic [CW-1:0] LAST = CW'(F - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;
    logic [CW-1:0] cnt;
    logic          s;
    logic          update;
    logic          glitch;

    // Plain shift chain: only chain[0] may resolve late, nothing sits between stages.
    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) chain <= {SYNC_STAGES{RESET_VAL}};
        else        chain <= {chain[SYNC_STAGES-2:0], async_in};
    end

    assign s      = chain[SYNC_STAGES-1];
    assign update = (s != sync_out) && (cnt == LAST);
    // A run that ends before reaching F samples is a rejected pulse.
    assign glitch = (s == sync_out) && (cnt != '0);

    always_ff @(posedge dst_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            sync_out    <= RESET_VAL;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            glitch_seen <= 1'b0;
        end else begin
            if (s == sync_out || update) cnt <= '0;
            else                         cnt <= cnt + 1'b1;
            if (update) sync_out <= s;
            rise_pulse <= update & s;
            fall_pulse <= update & ~s;
            if (glitch)          glitch_seen <= 1'b1;
            else if (glitch_clr) glitch_seen <= 1'b0;
        end
    end
endmodule

module multi_sync_filter #(
    parameter int   NUM_CH        = 4,
    parameter int   SYNC_STAGES   = 2,
    parameter int   FILTER_CYCLES = 4,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic              dst_clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    input  logic [NUM_CH-1:0] glitch_clr,
    output logic [NUM_CH-1:0] sync_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] glitch_seen
);
    // FILTER_CYCLES of 0 means "no filtering", same as a single sample.
    localparam int F  = (FILTER_CYCLES < 1) ? 1 : FILTER_CYCLES;
    localparam int CW = $clog2(F + 1);

    generate
        if (NUM_CH < 1 || SYNC_STAGES < 2 || FILTER_CYCLES < 0 || FILTER_CYCLES > 255) begin : g_bad_param
            $error("multi_sync_filter: illegal parameter set");
        end

        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            multi_sync_filter_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .F           (F),
                .CW          (CW),
                .RESET_VAL   (RESET_VAL)
            ) u_ch (
                .dst_clk     (dst_clk),
                .rst_n       (rst_n),
                .async_in    (async_in[i]),
                .glitch_clr  (glitch_clr[i]),
                .sync_out    (sync_out[i]),
                .rise_pulse  (rise_pulse[i]),
                .fall_pulse  (fall_pulse[i]),
                .glitch_seen (glitch_seen[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_sync_filter.sv
// Directed bench: default instance (2 stages, filter 4) and an unfiltered
// 3-stage instance, expected values worked out by hand per edge.

module tb_multi_sync_filter;
    logic       dst_clk = 1'b0;
    logic       rst_n, rst_n_b;
    logic [3:0] a_in, a_clr, a_out, a_rise, a_fall, a_gl;
    logic [3:0] b_in, b_clr, b_out, b_rise, b_fall, b_gl;
    int         total = 0;
    int         bad   = 0;

    always #5 dst_clk = ~dst_clk;

    multi_sync_filter u_dut_a (
        .dst_clk     (dst_clk),
        .rst_n       (rst_n),
        .async_in    (a_in),
        .glitch_clr  (a_clr),
        .sync_out    (a_out),
        .rise_pulse  (a_rise),
        .fall_pulse  (a_fall),
        .glitch_seen (a_gl)
    );

    multi_sync_filter #(
        .NUM_CH        (4),
        .SYNC_STAGES   (3),
        .FILTER_CYCLES (0),
        .RESET_VAL     (1'b0)
    ) u_dut_b (
        .dst_clk     (dst_clk),
        .rst_n       (rst_n_b),
        .async_in    (b_in),
        .glitch_clr  (b_clr),
        .sync_out    (b_out),
        .rise_pulse  (b_rise),
        .fall_pulse  (b_fall),
        .glitch_seen (b_gl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dst_clk);
        #1;
    endtask

    // Apply nin before edge 0 and follow channel A through edge 6.
    task automatic win_a(input logic [3:0] nin, input logic [3:0] oldo, input logic [3:0] gl_exp);
        a_in = nin;
        for (int e = 0; e <= 6; e++) begin
            tick();
            chk($sformatf("a_out e%0d", e),  {28'd0, a_out},  {28'd0, (e >= 5) ? nin : oldo});
            chk($sformatf("a_rise e%0d", e), {28'd0, a_rise}, {28'd0, (e == 5) ? (nin & ~oldo) : 4'h0});
            chk($sformatf("a_fall e%0d", e), {28'd0, a_fall}, {28'd0, (e == 5) ? (oldo & ~nin) : 4'h0});
            chk($sformatf("a_gl e%0d", e),   {28'd0, a_gl},   {28'd0, gl_exp});
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_n_b = 1'b0;
        a_in = 4'hF; a_clr = 4'h0;
        b_in = 4'h0; b_clr = 4'h0;

        // reset holds everything low even with inputs high
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("rst out",  {28'd0, a_out},  32'h0);
            chk("rst rise", {28'd0, a_rise | a_fall}, 32'h0);
            chk("rst gl",   {28'd0, a_gl},   32'h0);
        end
        #3;
        rst_n = 1'b1; rst_n_b = 1'b1;
        win_a(4'hF, 4'h0, 4'h0);

        // steps: all fall, ch0 rise, ch0 fall
        win_a(4'h0, 4'hF, 4'h0);
        win_a(4'h1, 4'h0, 4'h0);
        win_a(4'h0, 4'h1, 4'h0);

        // 3-sample pulse on ch1 is rejected and flagged
        for (int e = 0; e <= 7; e++) begin
            a_in = (e < 3) ? 4'h2 : 4'h0;
            tick();
            chk($sformatf("g out e%0d", e),  {28'd0, a_out},  32'h0);
            chk($sformatf("g edge e%0d", e), {28'd0, a_rise | a_fall}, 32'h0);
            chk($sformatf("g gl e%0d", e),   {28'd0, a_gl},   (e >= 5) ? 32'h2 : 32'h0);
        end
        a_clr = 4'h2;
        tick();
        chk("clr gl", {28'd0, a_gl}, 32'h0);
        a_clr = 4'h0;
        tick();
        chk("clr gl hold", {28'd0, a_gl}, 32'h0);

        // clear coinciding with a new glitch: set wins
        for (int e = 0; e <= 6; e++) begin
            a_in  = (e < 3) ? 4'h2 : 4'h0;
            a_clr = (e == 5) ? 4'h2 : 4'h0;
            tick();
            chk($sformatf("sc gl e%0d", e), {28'd0, a_gl}, (e >= 5) ? 32'h2 : 32'h0);
        end
        a_clr = 4'h2;
        tick();
        a_clr = 4'h0;
        chk("sc clr", {28'd0, a_gl}, 32'h0);

        // staggered steps on ch0 and ch2 resolve independently
        for (int e = 0; e <= 8; e++) begin
            a_in = (e < 2) ? 4'h1 : 4'h5;
            tick();
            chk($sformatf("st out e%0d", e),  {28'd0, a_out},
                {28'd0, ((e >= 5) ? 4'h1 : 4'h0) | ((e >= 7) ? 4'h4 : 4'h0)});
            chk($sformatf("st rise e%0d", e), {28'd0, a_rise},
                {28'd0, ((e == 5) ? 4'h1 : 4'h0) | ((e == 7) ? 4'h4 : 4'h0)});
        end

        // reset while ch3 is two samples into its run
        a_in = 4'hD;
        for (int e = 0; e <= 3; e++) begin
            tick();
            chk($sformatf("mr out e%0d", e), {28'd0, a_out}, 32'h5);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr async out", {28'd0, a_out}, 32'h0);
        chk("mr async gl",  {28'd0, a_gl | a_rise | a_fall}, 32'h0);
        tick();
        chk("mr held out", {28'd0, a_out}, 32'h0);
        #3;
        rst_n = 1'b1;
        win_a(4'hD, 4'h0, 4'h0);

        // unfiltered 3-stage instance: step up, step down, 1-cycle pulse
        for (int e = 0; e <= 4; e++) begin
            b_in = 4'h4;
            tick();
            chk($sformatf("b up out e%0d", e),  {28'd0, b_out},  (e >= 3) ? 32'h4 : 32'h0);
            chk($sformatf("b up rise e%0d", e), {28'd0, b_rise}, (e == 3) ? 32'h4 : 32'h0);
        end
        for (int e = 0; e <= 4; e++) begin
            b_in = 4'h0;
            tick();
            chk($sformatf("b dn out e%0d", e),  {28'd0, b_out},  (e >= 3) ? 32'h0 : 32'h4);
            chk($sformatf("b dn fall e%0d", e), {28'd0, b_fall}, (e == 3) ? 32'h4 : 32'h0);
        end
        for (int e = 0; e <= 5; e++) begin
            b_in = (e == 0) ? 4'h4 : 4'h0;
            tick();
            chk($sformatf("b p out e%0d", e),  {28'd0, b_out},  (e == 3) ? 32'h4 : 32'h0);
            chk($sformatf("b p rise e%0d", e), {28'd0, b_rise}, (e == 3) ? 32'h4 : 32'h0);
            chk($sformatf("b p fall e%0d", e), {28'd0, b_fall}, (e == 4) ? 32'h4 : 32'h0);
            chk($sformatf("b p gl e%0d", e),   {28'd0, b_gl},   32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
